// File: rtl/ioctl_upload_bridge.sv
// Core->HPS upload bridge: serves ioctl_rd byte reads from system memory over a req/ack port.
// Optional UPLOAD_CHECKSUM_EN adds a running mod-256 sum of delivered bytes on up_csum.
module ioctl_upload_bridge #(
  parameter int          AW       = 17,
  parameter logic [24:0] MAX_ADDR = 25'h001_FFFF,
  parameter logic [7:0]  FILL     = 8'hFF,
  parameter logic [7:0]  INDEX    = 8'd1,
  parameter int          TMO      = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_index,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          up_req,
  output logic [AW-1:0] up_addr,
  input  logic          up_ack,
  input  logic [7:0]    up_data,
  output logic [24:0]   up_count,
  output logic          up_timeout
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]    up_csum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t          state_r, state_s;
  logic            sel_s, sel_prev_r, start_s;
  logic [7:0]      tmo_r, tmo_s;
  logic [7:0]      din_s;
  logic            wait_s, req_s, timeout_s, deliver_s;
  logic [AW-1:0]   addr_s;
  logic [24:0]     count_s;

  // Next-state and next-output decode for the fetch sequencer.
  always_comb begin
    sel_s     = ioctl_upload && (ioctl_index == INDEX);
    start_s   = sel_s && !sel_prev_r;
    state_s   = state_r;
    tmo_s     = tmo_r;
    din_s     = ioctl_din;
    wait_s    = ioctl_wait;
    req_s     = up_req;
    addr_s    = up_addr;
    deliver_s = 1'b0;
    timeout_s = start_s ? 1'b0 : up_timeout;
    case (state_r)
      IDLE: begin
        if (sel_s && ioctl_rd) begin
          if (ioctl_addr > MAX_ADDR) begin
            din_s     = FILL;
            deliver_s = 1'b1;
          end else begin
            addr_s  = ioctl_addr[AW-1:0];
            req_s   = 1'b1;
            wait_s  = 1'b1;
            tmo_s   = 8'd0;
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // Session teardown abandons the fetch; ioctl_din keeps its last value.
        if (!ioctl_upload) begin
          req_s   = 1'b0;
          wait_s  = 1'b0;
          state_s = IDLE;
        end else if (up_ack) begin
          din_s   = up_data;
          req_s   = 1'b0;
          state_s = DONE;
        end else if (tmo_r == TMO_C) begin
          din_s     = FILL;
          req_s     = 1'b0;
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      DONE: begin
        wait_s    = 1'b0;
        deliver_s = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        req_s   = 1'b0;
        wait_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
    count_s = (start_s ? 25'd0 : up_count) + (deliver_s ? 25'd1 : 25'd0);
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      sel_prev_r <= 1'b0;
      tmo_r      <= 8'd0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      up_req     <= 1'b0;
      up_addr    <= '0;
      up_count   <= 25'd0;
      up_timeout <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_prev_r <= sel_s;
      tmo_r      <= tmo_s;
      ioctl_din  <= din_s;
      ioctl_wait <= wait_s;
      up_req     <= req_s;
      up_addr    <= addr_s;
      up_count   <= count_s;
      up_timeout <= timeout_s;
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] csum_s;
  logic [7:0] byte_s;

  // Delivered byte is FILL on the zero-wait path, otherwise the fetched byte already in ioctl_din.
  always_comb begin
    byte_s = (state_r == DONE) ? ioctl_din : FILL;
    csum_s = (start_s ? 8'h00 : up_csum) + (deliver_s ? byte_s : 8'h00);
  end

  // Running checksum register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up_csum <= 8'h00;
    end else begin
      up_csum <= csum_s;
    end
  end
`endif

endmodule

// File: tb/tb_ioctl_upload_bridge.sv
// Scoreboard bench for ioctl_upload_bridge: random reads checked against a byte-level session model.
module tb_ioctl_upload_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload, ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, up_req;
  logic [16:0] up_addr;
  logic        resp_ack, stray_ack;
  wire         up_ack;
  logic [7:0]  up_data;
  logic [24:0] up_count;
  logic        up_timeout;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]  up_csum;
`endif

  assign up_ack = resp_ack | stray_ack;

  ioctl_upload_bridge dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_index  (ioctl_index),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .up_req       (up_req),
    .up_addr      (up_addr),
    .up_ack       (up_ack),
    .up_data      (up_data),
    .up_count     (up_count),
    .up_timeout   (up_timeout)
`ifdef UPLOAD_CHECKSUM_EN
    ,
    .up_csum      (up_csum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  din;
    logic [24:0] cnt;
    logic        tmo;
    logic [7:0]  csum;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [24:0] m_count  = 25'd0;
  logic        m_tmo    = 1'b0;
  logic [7:0]  m_csum   = 8'h00;
  logic [7:0]  mem_tab [int];
  int          resp_delay = 0;
  bit          resp_noack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    logic [31:0] v;
    v = a;
    if (mem_tab.exists(a)) return mem_tab[a];
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  // Memory responder: acks resp_delay negedges after seeing up_req, unless told to stay silent.
  initial begin
    int rcnt;
    rcnt     = 0;
    resp_ack = 1'b0;
    up_data  = 8'h00;
    forever begin
      @(negedge clk_sys);
      resp_ack = 1'b0;
      if (up_req && !resp_noack) begin
        if (rcnt >= resp_delay) begin
          resp_ack = 1'b1;
          up_data  = mem_byte(int'(up_addr));
          rcnt     = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: every delivery shows as up_count stepping by one; compare against the queue head.
  initial begin
    logic [24:0] prev;
    exp_t        e;
    prev = 25'd0;
    forever begin
      @(negedge clk_sys);
      if (reset_n && up_count == prev + 25'd1) begin
        if (q.size() == 0) begin
          check("unexpected_delivery", 32'(up_count), 32'(prev));
        end else begin
          e = q.pop_front();
          check("din", 32'(ioctl_din), 32'(e.din));
          check("count", 32'(up_count), 32'(e.cnt));
          check("timeout", 32'(up_timeout), 32'(e.tmo));
`ifdef UPLOAD_CHECKSUM_EN
          check("csum", 32'(up_csum), 32'(e.csum));
`endif
        end
      end
      prev = up_count;
    end
  end

  task automatic do_read(input logic [24:0] a, input int delay, input bit noack, input bit viol);
    exp_t e;
    int   lat;
    bit   inr;
    inr        = (a <= 25'h001_FFFF);
    resp_delay = delay;
    resp_noack = noack;
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    m_count    = m_count + 25'd1;
    if (!inr) e.din = 8'hFF;
    else if (noack) begin
      e.din = 8'hFF;
      m_tmo = 1'b1;
    end else e.din = mem_byte(int'(a));
    m_csum = m_csum + e.din;
    e.cnt  = m_count;
    e.tmo  = m_tmo;
    e.csum = m_csum;
    q.push_back(e);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    lat      = 1;
    check("wait_after_rd", 32'(ioctl_wait), 32'(inr));
    check("req_after_rd", 32'(up_req), 32'(inr));
    if (inr) begin
      check("up_addr", 32'(up_addr), 32'(a[16:0]));
      if (viol) begin
        ioctl_rd   = 1'b1;
        ioctl_addr = a ^ 25'h1;
      end
    end
    while (ioctl_wait && lat < 400) begin
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      lat++;
    end
    if (ioctl_wait) check("wait_stuck", 32'(ioctl_wait), 32'd0);
    else if (!inr) check("lat_oor", 32'(lat), 32'd1);
    else if (noack) check("lat_tmo_window", 32'(lat >= 250 && lat <= 260), 32'd1);
    else check("lat_ack", 32'(lat), 32'(3 + delay));
    @(negedge clk_sys);
  endtask

  task automatic start_session(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    ioctl_index  = idx;
    if (idx == 8'd1) begin
      m_count = 25'd0;
      m_tmo   = 1'b0;
      m_csum  = 8'h00;
    end
    @(negedge clk_sys);
    if (idx == 8'd1) begin
      check("session_count", 32'(up_count), 32'd0);
      check("session_timeout", 32'(up_timeout), 32'd0);
`ifdef UPLOAD_CHECKSUM_EN
      check("session_csum", 32'(up_csum), 32'd0);
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  saved_din;
    logic [24:0] saved_cnt, a;
    bit          req_seen, wait_seen;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'd0;
    ioctl_index  = 8'd0;
    stray_ack    = 1'b0;
    mem_tab[32'h10]  = 8'hA5;
    mem_tab[32'h100] = 8'h80;
    mem_tab[32'h101] = 8'h90;
    mem_tab[32'h102] = 8'h10;
    mem_tab[32'h40]  = 8'h3C;
    repeat (3) @(negedge clk_sys);
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req", 32'(up_req), 32'd0);
    check("rst_addr", 32'(up_addr), 32'd0);
    check("rst_count", 32'(up_count), 32'd0);
    check("rst_timeout", 32'(up_timeout), 32'd0);
`ifdef UPLOAD_CHECKSUM_EN
    check("rst_csum", 32'(up_csum), 32'd0);
`endif
    reset_n = 1'b1;

    start_session(8'd1);
    do_read(25'h10, 1, 1'b0, 1'b0);
    do_read(25'h20000, 0, 1'b0, 1'b0);
    do_read(25'h5, 0, 1'b0, 1'b1);
    do_read(25'h1234, 0, 1'b1, 1'b0);
    start_session(8'd1);
    do_read(25'h100, 2, 1'b0, 1'b0);
    do_read(25'h101, 0, 1'b0, 1'b0);
    do_read(25'h102, 3, 1'b0, 1'b0);
`ifdef UPLOAD_CHECKSUM_EN
    check("csum_three_bytes", 32'(up_csum), 32'h20);
`endif
    start_session(8'd1);

    // Foreign index: strobes must be ignored entirely.
    do_read(25'h40, 0, 1'b0, 1'b0);
    start_session(8'd2);
    saved_din = ioctl_din;
    saved_cnt = up_count;
    req_seen  = 1'b0;
    wait_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'($urandom_range(0, 32'h1FFFF));
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      req_seen  = req_seen | up_req;
      wait_seen = wait_seen | ioctl_wait;
      @(negedge clk_sys);
      req_seen  = req_seen | up_req;
      wait_seen = wait_seen | ioctl_wait;
    end
    check("idx2_req", 32'(req_seen), 32'd0);
    check("idx2_wait", 32'(wait_seen), 32'd0);
    check("idx2_count", 32'(up_count), 32'(saved_cnt));
    check("idx2_din", 32'(ioctl_din), 32'(saved_din));

    start_session(8'd1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) a = 25'h20000 + 25'($urandom_range(0, 32'h1FDFFFF));
      else a = 25'($urandom_range(0, 32'h1FFFF));
      do_read(a, int'($urandom_range(0, 5)), (i == 17), ($urandom_range(0, 3) == 0));
    end

    // Session drop while a fetch is outstanding.
    saved_din  = ioctl_din;
    saved_cnt  = up_count;
    resp_noack = 1'b1;
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h55;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("abort_pre_wait", 32'(ioctl_wait), 32'd1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_req", 32'(up_req), 32'd0);
    check("abort_wait", 32'(ioctl_wait), 32'd0);
    check("abort_din", 32'(ioctl_din), 32'(saved_din));
    check("abort_count", 32'(up_count), 32'(saved_cnt));

    // Asynchronous reset in the middle of a fetch, then a stray ack.
    start_session(8'd1);
    resp_noack = 1'b1;
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h66;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rstmid_pre_req", 32'(up_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_req", 32'(up_req), 32'd0);
    check("rstmid_wait", 32'(ioctl_wait), 32'd0);
    check("rstmid_din", 32'(ioctl_din), 32'd0);
    check("rstmid_count", 32'(up_count), 32'd0);
    @(negedge clk_sys);
    reset_n    = 1'b1;
    resp_noack = 1'b0;
    m_count    = 25'd0;
    m_tmo      = 1'b0;
    m_csum     = 8'h00;
    stray_ack  = 1'b1;
    @(negedge clk_sys);
    stray_ack = 1'b0;
    @(negedge clk_sys);
    check("stray_din", 32'(ioctl_din), 32'd0);
    check("stray_req", 32'(up_req), 32'd0);
    check("stray_wait", 32'(ioctl_wait), 32'd0);
    check("stray_count", 32'(up_count), 32'd0);
    do_read(25'h10, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk_sys);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
